// File: rtl/inst_mem_sync.sv
// Instruction memory for the fetch stage; optional per-word parity under IMEM_PARITY_EN.
// Latency: 1 cycle from accepted fetch to registered inst/inst_valid/fault_*.
// Backpressure: inst_stall freezes a valid response and drops fetch_ready; requests are not queued.
module inst_mem_sync #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic                       fetch_ready,
  output logic [DATA_W-1:0]          inst,
  output logic                       inst_valid,
  input  logic                       inst_stall,
  output logic                       fault_align,
  output logic                       fault_range,
  output logic                       fault_parity,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [DATA_W-1:0]          prog_data,
  input  logic                       prog_perr
);

  localparam int IDX_W = $clog2(DEPTH);
  // Address is widened so the index slice is always legal, even for narrow ADDR_W.
  localparam int PAD_W = (ADDR_W > IDX_W + 2) ? ADDR_W : IDX_W + 2;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PAD_W-1:0]  addr_pad;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic              align_err;
  logic              range_err;
  logic              parity_err;
  logic              hold;
  logic              accept;

  assign addr_pad  = PAD_W'(fetch_addr);
  assign idx       = addr_pad[IDX_W+1:2];
  assign rd_word   = mem[idx];
  assign align_err = |fetch_addr[1:0];

  generate
    if (PAD_W > IDX_W + 2) begin : g_range
      assign range_err = |addr_pad[PAD_W-1:IDX_W+2];
    end else begin : g_no_range
      assign range_err = 1'b0;
    end
  endgenerate

  assign hold        = inst_valid & inst_stall;
  assign fetch_ready = ~hold;
  assign accept      = fetch_req & fetch_ready;

  // Nonblocking write gives read-before-write on a same-edge read of the same index.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (prog_we) begin
      par_mem[prog_addr] <= (^prog_data) ^ prog_perr;
    end
  end

  assign parity_err = (^rd_word) ^ par_mem[idx];
`else
  logic unused_prog_perr;

  assign unused_prog_perr = prog_perr;
  assign parity_err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst         <= '0;
      inst_valid   <= 1'b0;
      fault_align  <= 1'b0;
      fault_range  <= 1'b0;
      fault_parity <= 1'b0;
    end else if (hold) begin
      inst         <= inst;
      inst_valid   <= 1'b1;
      fault_align  <= fault_align;
      fault_range  <= fault_range;
      fault_parity <= fault_parity;
    end else if (accept) begin
      inst_valid   <= 1'b1;
      fault_align  <= align_err;
      fault_range  <= ~align_err & range_err;
      if (align_err | range_err) begin
        inst         <= '0;
        fault_parity <= 1'b0;
      end else begin
        inst         <= rd_word;
        fault_parity <= parity_err;
      end
    end else begin
      // Data register keeps its last word; flags are only meaningful alongside inst_valid.
      inst_valid   <= 1'b0;
      fault_align  <= 1'b0;
      fault_range  <= 1'b0;
      fault_parity <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_mem_sync.sv
// Randomised scoreboard bench for inst_mem_sync with directed fetch, stall, fault and write-collision cases.
module tb_inst_mem_sync;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int IDX_W  = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_ready;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              inst_stall = 1'b0;
  logic              fault_align;
  logic              fault_range;
  logic              fault_parity;
  logic              prog_we = 1'b0;
  logic [IDX_W-1:0]  prog_addr = '0;
  logic [DATA_W-1:0] prog_data = '0;
  logic              prog_perr = 1'b0;

  inst_mem_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .inst(inst), .inst_valid(inst_valid), .inst_stall(inst_stall),
    .fault_align(fault_align), .fault_range(fault_range), .fault_parity(fault_parity),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_perr(prog_perr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] inst;
    logic              fa;
    logic              fr;
    logic              fp;
    int                edge_n;
  } exp_t;

  exp_t              q[$];
  logic [DATA_W-1:0] model_mem  [DEPTH];
  bit                model_perr [DEPTH];
  int                checks   = 0;
  int                failures = 0;
  int                edge_cnt = 0;
  bit                mon_en   = 0;

  always @(posedge clk) edge_cnt++;

  // Reference: fault precedence and word lookup straight from the address arithmetic.
  function automatic exp_t model_resp(input logic [ADDR_W-1:0] a);
    exp_t r;
    int   w;
    r.inst = '0; r.fa = 0; r.fr = 0; r.fp = 0; r.edge_n = 0;
    if (a % 4 != 0) begin
      r.fa = 1;
    end else if (a >= DEPTH * 4) begin
      r.fr = 1;
    end else begin
      w = int'(a / 4);
      r.inst = model_mem[w];
`ifdef IMEM_PARITY_EN
      r.fp = model_perr[w];
`endif
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One cycle of stimulus; acceptance is predicted from the ready seen after inputs settle.
  task automatic step(input logic req, input logic [ADDR_W-1:0] addr, input logic stall,
                      input logic we, input logic [IDX_W-1:0] pa, input logic [DATA_W-1:0] pd,
                      input logic perr, output bit acc);
    exp_t e;
    @(negedge clk);
    fetch_req = req; fetch_addr = addr; inst_stall = stall;
    prog_we = we; prog_addr = pa; prog_data = pd; prog_perr = perr;
    #1;
    acc = req && fetch_ready;
    if (acc) begin
      e = model_resp(addr);
      e.edge_n = edge_cnt + 1;
      q.push_back(e);
    end
    if (we) begin
      model_mem[pa]  = pd;
      model_perr[pa] = perr;
    end
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] addr, input logic stall, input bit exp_acc, input string name);
    bit acc;
    step(1'b1, addr, stall, 1'b0, '0, '0, 1'b0, acc);
    check(name, 64'(acc), 64'(exp_acc));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, acc);
  endtask

  task automatic prog(input logic [IDX_W-1:0] pa, input logic [DATA_W-1:0] pd, input logic perr);
    bit acc;
    step(1'b0, '0, 1'b0, 1'b1, pa, pd, perr, acc);
  endtask

  // Monitor: new responses pop the scoreboard; held responses must not change.
  initial begin
    logic [DATA_W+2:0] snap;
    bit                hold_before;
    exp_t              e;
    snap = '0;
    forever begin
      @(posedge clk);
      hold_before = inst_valid && inst_stall;
      #1;
      if (mon_en) begin
        if (hold_before) begin
          check("held_valid", 64'(inst_valid), 64'd1);
          check("held_resp", 64'({inst, fault_align, fault_range, fault_parity}), 64'(snap));
          check("held_ready", 64'(fetch_ready), 64'd0);
        end else if (inst_valid) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_resp actual=valid inst=%h required=no response", inst);
          end else begin
            e = q.pop_front();
            check("latency_edge", 64'(edge_cnt), 64'(e.edge_n));
            check("resp", 64'({inst, fault_align, fault_range, fault_parity}),
                  64'({e.inst, e.fa, e.fr, e.fp}));
          end
          snap = {inst, fault_align, fault_range, fault_parity};
        end else begin
          check("idle_inst_kept", 64'(inst), 64'(snap[DATA_W+2:3]));
          if (q.size() > 0 && q[0].edge_n <= edge_cnt) begin
            checks++; failures++;
            $display("FAIL missing_resp actual=no valid required=inst %h at edge %0d", q[0].inst, q[0].edge_n);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    bit                acc;
    logic              cur_req;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] a;

    // Reset state
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_faults", 64'({fault_align, fault_range, fault_parity}), 64'd0);
    check("rst_ready", 64'(fetch_ready), 64'd1);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) prog(IDX_W'(i), $urandom(), 1'b0);
    prog(5, 32'h3401_1234, 1'b0);
    prog(7, 32'h0000_1111, 1'b0);

    // Reset mid-response drops it; memory survives
    fetch(32'h14, 1'b0, 1'b1, "acc_pre_rst");
    idle(1);
    check("pre_rst_valid", 64'(inst_valid), 64'd1);
    check("pre_rst_inst", 64'(inst), 64'h3401_1234);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(inst_valid), 64'd0);
    check("mid_rst_inst", 64'(inst), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    check("post_rst_valid", 64'(inst_valid), 64'd0);
    check("post_rst_inst", 64'(inst), 64'd0);
    check("post_rst_faults", 64'({fault_align, fault_range, fault_parity}), 64'd0);
    q.delete();
    @(negedge clk) mon_en = 1;

    // Basic fetch and back-to-back with stall/hold
    fetch(32'h14, 1'b0, 1'b1, "acc_14");
    idle(1);
    fetch(32'h14, 1'b0, 1'b1, "acc_b2b_14");
    fetch(32'h18, 1'b0, 1'b1, "acc_b2b_18");
    fetch(32'h1C, 1'b0, 1'b1, "acc_b2b_1c");
    fetch(32'h20, 1'b1, 1'b0, "stall_20_a");
    fetch(32'h20, 1'b1, 1'b0, "stall_20_b");
    fetch(32'h20, 1'b0, 1'b1, "release_20");
    idle(2);

    // Faults and boundary
    fetch(32'h16, 1'b0, 1'b1, "acc_align");
    fetch(32'h80, 1'b0, 1'b1, "acc_range");
    fetch(32'h7C, 1'b0, 1'b1, "acc_last");
    fetch(32'h83, 1'b0, 1'b1, "acc_both");
    fetch(32'hFFFF_FF80, 1'b0, 1'b1, "acc_far");
    idle(1);

    // Same-edge write and read of idx 7
    step(1'b1, 32'h1C, 1'b0, 1'b1, 7, 32'hDEAD_BEEF, 1'b0, acc);
    check("acc_collide", 64'(acc), 64'd1);
    fetch(32'h1C, 1'b0, 1'b1, "acc_refetch");
    idle(1);

    // Injected parity error on idx 3
    prog(3, 32'hA5A5_0F0F, 1'b1);
    fetch(32'h0C, 1'b0, 1'b1, "acc_parity");
    prog(3, 32'hA5A5_0F0F, 1'b0);
    fetch(32'h0C, 1'b0, 1'b1, "acc_parity_clean");
    idle(1);

    // Randomised traffic with stable-until-accepted requester
    cur_req = 0; cur_addr = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!cur_req && $urandom_range(0, 3) != 0) begin
        cur_req = 1;
        case ($urandom_range(0, 9))
          0: cur_addr = 32'($urandom_range(0, 127) | $urandom_range(1, 3));
          1: cur_addr = 32'(DEPTH * 4 + $urandom_range(0, 63) * 4);
          2: cur_addr = $urandom();
          default: cur_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
        endcase
      end
      a = cur_addr;
      step(cur_req, a, ($urandom_range(0, 9) < 3), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 1) == 0) ? IDX_W'(a[IDX_W+1:2]) : IDX_W'($urandom_range(0, DEPTH - 1)),
           $urandom(), ($urandom_range(0, 7) == 0), acc);
      if (acc) cur_req = 0;
    end
    idle(4);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
